// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Holds the FSM state encoding, port indices and default bus widths.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int CPU_PORT   = 0;
  localparam int AUX_PORT   = 1;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Wide enough for the largest legal wait-state count (15).
  localparam int CNT_W      = 4;

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter that paces the SRAM strobe window.
// Holds at zero once expired; zero flag is a compare on the count register.
module sram_wait_timer
  import sram_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single asynchronous SRAM (port 0 = CPU, port 1 = aux).
// Build option: define ARB_FIXED_PRIORITY_EN to make port 0 win every tie instead of round-robin.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no access in flight; arbitrate and latch the winning request
//   ACCESS  | strobes asserted, wait timer running down to zero
//   RECOVER | strobes released, write data held, done pulsed to the winner
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_data_oe
);

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pick;
  logic                timer_load;
  logic                timer_zero;

`ifndef ARB_FIXED_PRIORITY_EN
  logic                last_grant_q, last_grant_d;
`endif

  sram_wait_timer #(
    .W(CNT_W)
  ) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (timer_load),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .zero     (timer_zero)
  );

  always_comb begin
    pick = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
    pick = ~req[CPU_PORT];
`else
    // A tie goes to whichever port did not win last; a lone requester always wins.
    if (req == 2'b11) begin
      pick = ~last_grant_q;
    end else begin
      pick = req[AUX_PORT];
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    timer_load   = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d      = pick;
          we_d         = we[pick];
          addr_d       = pick ? addr1 : addr0;
          wdata_d      = pick ? wdata1 : wdata0;
          timer_load   = 1'b1;
          state_d      = ACCESS;
`ifndef ARB_FIXED_PRIORITY_EN
          last_grant_d = pick;
`endif
        end
      end
      ACCESS: begin
        if (timer_zero) begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they change only on the clock edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_data_oe <= 1'b0;
      done         <= 2'b00;
      busy         <= 1'b0;
      rdata        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant_q <= last_grant_d;
`endif
      sram_ce_n    <= (state_d != ACCESS);
      sram_oe_n    <= !((state_d == ACCESS) && !we_d);
      sram_we_n    <= !((state_d == ACCESS) && we_d);
      sram_data_oe <= we_d && ((state_d == ACCESS) || (state_d == RECOVER));
      done         <= (state_d == RECOVER) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
      busy         <= (state_d != IDLE);
      if ((state_q == ACCESS) && timer_zero && !we_q) begin
        rdata <= sram_rdata;
      end
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand-written corner cases,
// and random traffic against a transaction-level model of arbitration, timing and memory.
module tb_sram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int WAIT = 4;

  logic          Clk;
  logic          Reset;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe;

  int errors = 0;
  int checks = 0;

  sram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .rdata(rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_data_oe(sram_data_oe)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Asynchronous SRAM model: preloaded pattern, written on strobes at each clock edge.
  logic [15:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    mem[16'h3000] = 16'h1234;
    forever begin
      @(posedge Clk);
      if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_wdata;
    end
  end
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  function automatic logic [1:0] oh(input int p);
    return (p != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic wait_done(input int limit, output int n, output int rc, output int wc,
                           output int dc, output logic [1:0] dn);
    n = 0; rc = 0; wc = 0; dc = 0; dn = 2'b00;
    while (dn == 2'b00 && n < limit) begin
      tick();
      n++;
      if (!sram_oe_n)   rc++;
      if (!sram_we_n)   wc++;
      if (sram_data_oe) dc++;
      dn = done;
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0, a1, d0, d1;
    int          first;
    logic [15:0] rd1, rd2;
  } vec_t;

  vec_t vecs [7];

  // Random-phase model state
  logic [15:0] shadow [0:65535];
  int          free_at, done_cyc, mport, model_last, w;
  logic        pend_read;
  logic [15:0] pend_data, exp_rdata;
  logic [1:0]  exp_done, hold_off;

  initial begin
    int n, rc, wc, dc, other, fp;
    logic [1:0]  dn;
    logic        wr, addr_ok, saw_done;
    logic [15:0] a, d;

    vecs[0] = '{2'b01, 2'b00, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h1234, 16'h0000};
    vecs[1] = '{2'b10, 2'b10, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 1, 16'h1234, 16'h0000};
    vecs[2] = '{2'b10, 2'b00, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h0000};
    vecs[3] = '{2'b01, 2'b01, 16'h0020, 16'h0000, 16'h0055, 16'h0000, 0, 16'hBEEF, 16'h0000};
`ifdef ARB_FIXED_PRIORITY_EN
    vecs[4] = '{2'b11, 2'b00, 16'h0020, 16'h3000, 16'h0000, 16'h0000, 0, 16'h0055, 16'h1234};
    vecs[5] = '{2'b11, 2'b11, 16'h0030, 16'h0031, 16'h1111, 16'h2222, 0, 16'h1234, 16'h1234};
    vecs[6] = '{2'b11, 2'b00, 16'h0030, 16'h0031, 16'h0000, 16'h0000, 0, 16'h1111, 16'h2222};
`else
    vecs[4] = '{2'b11, 2'b00, 16'h0020, 16'h3000, 16'h0000, 16'h0000, 1, 16'h1234, 16'h0055};
    vecs[5] = '{2'b11, 2'b11, 16'h0030, 16'h0031, 16'h1111, 16'h2222, 1, 16'h0055, 16'h0055};
    vecs[6] = '{2'b11, 2'b00, 16'h0030, 16'h0031, 16'h0000, 16'h0000, 1, 16'h2222, 16'h1111};
`endif

    req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    do_reset();

    check("reset_done", done, 2'b00);
    check("reset_rdata", rdata, 16'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 4'b1110);
    check("reset_addr", sram_addr, 16'h0);
    check("reset_wdata", sram_wdata, 16'h0);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      we = vecs[i].we; addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      wdata0 = vecs[i].d0; wdata1 = vecs[i].d1; req = vecs[i].req;
      fp = vecs[i].first;
      wait_done(20, n, rc, wc, dc, dn);
      check($sformatf("vec%0d_done_port", i), dn, oh(fp));
      check($sformatf("vec%0d_latency", i), n, WAIT + 1);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rd1);
      wr = vecs[i].we[fp];
      if (wr) begin
        check($sformatf("vec%0d_we_cycles", i), wc, WAIT);
        check($sformatf("vec%0d_data_oe_cycles", i), dc, WAIT + 1);
        check($sformatf("vec%0d_oe_cycles", i), rc, 0);
        a = (fp != 0) ? vecs[i].a1 : vecs[i].a0;
        d = (fp != 0) ? vecs[i].d1 : vecs[i].d0;
        check($sformatf("vec%0d_mem", i), mem[a], d);
      end else begin
        check($sformatf("vec%0d_oe_cycles", i), rc, WAIT);
        check($sformatf("vec%0d_data_oe_cycles", i), dc, 0);
        check($sformatf("vec%0d_we_cycles", i), wc, 0);
      end
      req[fp] = 1'b0;
      if (req != 2'b00) begin
        other = 1 - fp;
        wait_done(20, n, rc, wc, dc, dn);
        check($sformatf("vec%0d_second_port", i), dn, oh(other));
        check($sformatf("vec%0d_second_latency", i), n, WAIT + 2);
        check($sformatf("vec%0d_second_rdata", i), rdata, vecs[i].rd2);
        req = 2'b00;
      end
      tick();
      tick();
      check($sformatf("vec%0d_idle_busy", i), busy, 1'b0);
    end

    // Both ports requesting continuously from reset
    req = 2'b11; we = 2'b00; addr0 = 16'h3000; addr1 = 16'h0010;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_done(20, n, rc, wc, dc, dn);
`ifdef ARB_FIXED_PRIORITY_EN
      check($sformatf("cont%0d_port", k), dn, 2'b01);
`else
      check($sformatf("cont%0d_port", k), dn, oh(k % 2));
`endif
      check($sformatf("cont%0d_spacing", k), n, (k == 0) ? WAIT + 1 : WAIT + 2);
    end
    req = 2'b00;
    tick();
    tick();

    // Reset in the second ACCESS cycle of a write
    we = 2'b10; addr1 = 16'h0040; wdata1 = 16'h7777; req = 2'b10;
    tick();
    tick();
    check("midrst_busy_before", busy, 1'b1);
    check("midrst_we_n_before", sram_we_n, 1'b0);
    Reset = 1'b1;
    tick();
    check("midrst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 4'b1110);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 2'b00);
    check("midrst_rdata", rdata, 16'h0);
    Reset = 1'b0; req = 2'b00;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done != 2'b00) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);

    // Address changes and req drops mid-access
    we = 2'b00; addr0 = 16'h3000; req = 2'b01;
    tick();
    tick();
    addr0 = 16'hFFFF; req = 2'b00;
    addr_ok = (sram_addr == 16'h3000);
    n = 0; dn = 2'b00;
    while (dn == 2'b00 && n < 20) begin
      tick();
      n++;
      if (sram_addr != 16'h3000) addr_ok = 1'b0;
      dn = done;
    end
    check("midchg_addr_held", addr_ok, 1'b1);
    check("midchg_done", dn, 2'b01);
    check("midchg_rdata", rdata, 16'h1234);
    tick();
    tick();

    // Random traffic against a transaction-level model
    for (int i = 0; i < 65536; i++) shadow[i] = init_val(16'(i));
    req = 2'b00;
    do_reset();
    free_at = 0; done_cyc = -1; mport = 0; model_last = 1;
    pend_read = 1'b0; pend_data = '0; exp_rdata = '0; hold_off = 2'b00;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      exp_done = (cyc == done_cyc) ? oh(mport) : 2'b00;
      if (cyc == done_cyc && pend_read) exp_rdata = pend_data;
      check("rand_done", done, exp_done);
      check("rand_rdata", rdata, exp_rdata);
      check("rand_busy", busy, (cyc < free_at) ? 1'b1 : 1'b0);

      for (int p = 0; p < 2; p++) begin
        if (done[p]) begin
          req[p] = 1'b0;
          hold_off[p] = 1'b1;
        end else if (hold_off[p]) begin
          hold_off[p] = 1'b0;
        end else if (!req[p] && $urandom_range(0, 2) == 0) begin
          we[p] = 1'($urandom_range(0, 1));
          if (p == 0) begin
            addr0 = 16'h0100 + 16'($urandom_range(0, 15));
            wdata0 = 16'($urandom);
          end else begin
            addr1 = 16'h0100 + 16'($urandom_range(0, 15));
            wdata1 = 16'($urandom);
          end
          req[p] = 1'b1;
        end
      end

      if (cyc >= free_at && req != 2'b00) begin
        if (req == 2'b11) begin
`ifdef ARB_FIXED_PRIORITY_EN
          w = 0;
`else
          w = 1 - model_last;
`endif
        end else begin
          w = req[1] ? 1 : 0;
        end
        model_last = w;
        mport = w;
        done_cyc = cyc + WAIT + 1;
        free_at = cyc + WAIT + 2;
        a = (w != 0) ? addr1 : addr0;
        if (we[w]) begin
          shadow[a] = (w != 0) ? wdata1 : wdata0;
          pend_read = 1'b0;
        end else begin
          pend_data = shadow[a];
          pend_read = 1'b1;
        end
      end
      tick();
    end
    req = 2'b00;
    for (int k = 0; k < WAIT + 4; k++) tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rand_mem_%0d", i), mem[16'h0100 + 16'(i)], shadow[16'h0100 + 16'(i)]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
